hclk_divider: RTL and testbench

- Integer clock divider for the fast serializer clock domain, e.g. the HDMI 5x pixel clock (126 MHz) divided by 5 down to the 25.2 MHz pixel clock.
- Held in reset until the upstream PLL reports lock; release is usually driven by the PLL lock signal.
- Produces a divided clock with a deterministic phase relative to reset release.
- Supports a one-cycle phase slip through CALIB, so the word clock can be aligned to the serializers.

---
 rtl/hclk_divider.sv | 100 ++++++++++
 tb/tb_hclk_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/hclk_divider.sv
// hclk_divider: divides HCLKIN by DIV_MODE (2..8) with a phase fixed to reset release.
// Define HCLK_DIVIDER_CALIB_EN to enable the one-cycle phase slip on a CALIB rise.
module hclk_divider #(
  parameter int DIV_MODE = 5
) (
  input  logic HCLKIN,
  input  logic RESETN,
  input  logic CALIB,
  output logic CLKOUT
);

  localparam int              PH_W     = (DIV_MODE > 2) ? $clog2(DIV_MODE) : 1;
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(DIV_MODE - 1);
  localparam logic [PH_W-1:0] PH_HIGH  = PH_W'(DIV_MODE / 2);
  localparam bit              ODD_MODE = (DIV_MODE % 2) == 1;

  if ((DIV_MODE < 2) || (DIV_MODE > 8)) begin : g_bad_div
    $error("hclk_divider: DIV_MODE %0d is outside the legal range 2..8", DIV_MODE);
  end

  logic [PH_W-1:0] ph_q;
  logic [PH_W-1:0] ph_d;
  logic            p_q;
  logic            p_d;

  function automatic logic [PH_W-1:0] ph_next_f(input logic [PH_W-1:0] ph);
    if (ph == PH_LAST) begin
      ph_next_f = '0;
    end else begin
      ph_next_f = ph + PH_W'(1);
    end
  endfunction

`ifdef HCLK_DIVIDER_CALIB_EN
  logic cd_q;
  logic slip_s;

  // CALIB history; resets high so a CALIB already high at release never slips
  always_ff @(posedge HCLKIN or negedge RESETN) begin
    if (!RESETN) begin
      cd_q <= 1'b1;
    end else begin
      cd_q <= CALIB;
    end
  end

  assign slip_s = CALIB & ~cd_q;

  // Next phase and posedge level; a CALIB rise freezes both for one cycle
  always_comb begin
    ph_d = ph_q;
    p_d  = p_q;
    if (slip_s) begin
      ph_d = ph_q;
      p_d  = p_q;
    end else begin
      ph_d = ph_next_f(ph_q);
      p_d  = (ph_d < PH_HIGH);
    end
  end
`else
  logic calib_unused_s;
  assign calib_unused_s = CALIB;

  // Next phase and posedge level; phase advances every rising edge
  always_comb begin
    ph_d = ph_next_f(ph_q);
    p_d  = (ph_d < PH_HIGH);
  end
`endif

  // Phase counter and posedge register; reset parks the phase so edge 0 lands on ph=0
  always_ff @(posedge HCLKIN or negedge RESETN) begin
    if (!RESETN) begin
      ph_q <= PH_LAST;
      p_q  <= 1'b0;
    end else begin
      ph_q <= ph_d;
      p_q  <= p_d;
    end
  end

  if (ODD_MODE) begin : g_odd
    logic n_q;

    // Half-cycle delayed copy of p; extends the high time by half a fast period
    always_ff @(negedge HCLKIN or negedge RESETN) begin
      if (!RESETN) begin
        n_q <= 1'b0;
      end else begin
        n_q <= p_q;
      end
    end

    assign CLKOUT = p_q | n_q;
  end else begin : g_even
    assign CLKOUT = p_q;
  end

endmodule

// File: tb/tb_hclk_divider.sv
// Bench for hclk_divider: five instances (DIV_MODE 2,3,4,5,8) sampled every half period
// against a duty-cycle model, plus phase-slip and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_hclk_divider;

  typedef struct {
    int div;
    int hi_ns;
    int per_ns;
  } rec_t;

  rec_t       tbl [5];
  logic       hclk;
  logic       rstn;
  logic       calib;
  logic [4:0] clk_o;

  int         checks;
  int         errors;
  int         h;
  logic [4:0] cur_v;
  logic [4:0] prev_v;
  logic [4:0] exp_q [$];
  int         rise_h [5];
  int         hi_h   [5];
  int         per_h  [5];
  bit         rise_ok [5];
  int         n_nom [5];
  int         n_str [5];
  int         n_oth [5];
  bit         found;

`ifdef HCLK_DIVIDER_CALIB_EN
  localparam int EXP_SLIPS = 1;
`else
  localparam int EXP_SLIPS = 0;
`endif

  hclk_divider #(.DIV_MODE(2)) u_div2 (.HCLKIN(hclk), .RESETN(rstn), .CALIB(calib), .CLKOUT(clk_o[0]));
  hclk_divider #(.DIV_MODE(3)) u_div3 (.HCLKIN(hclk), .RESETN(rstn), .CALIB(calib), .CLKOUT(clk_o[1]));
  hclk_divider #(.DIV_MODE(4)) u_div4 (.HCLKIN(hclk), .RESETN(rstn), .CALIB(calib), .CLKOUT(clk_o[2]));
  hclk_divider #(.DIV_MODE(5)) u_div5 (.HCLKIN(hclk), .RESETN(rstn), .CALIB(calib), .CLKOUT(clk_o[3]));
  hclk_divider #(.DIV_MODE(8)) u_div8 (.HCLKIN(hclk), .RESETN(rstn), .CALIB(calib), .CLKOUT(clk_o[4]));

  initial hclk = 1'b0;
  always #4 hclk = ~hclk;

  // CLKOUT is high for exactly DIV_MODE half periods, starting at the first rise after release
  function automatic logic [4:0] model_f(input int hh);
    logic [4:0] m;
    m = '0;
    for (int i = 0; i < 5; i++) begin
      m[i] = ((hh % (2 * tbl[i].div)) < tbl[i].div);
    end
    return m;
  endfunction

  task automatic check_v(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s h=%0d got=%b exp=%b", name, h, got, exp);
    end
  endtask

  task automatic check_i(input string name, input int idx, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s div=%0d got=%0d exp=%0d", name, tbl[idx].div, got, exp);
    end
  endtask

  task automatic clear_edges();
    prev_v = '0;
    for (int i = 0; i < 5; i++) begin
      rise_ok[i] = 1'b0;
      rise_h[i]  = 0;
    end
  endtask

  // One half period: sample 1 ns and 3 ns after the edge, track CLKOUT rise/fall spacing
  task automatic sample_half(input bit use_model);
    logic [4:0] v2;
    logic [4:0] e;
    e = '0;
    if (h % 2 == 0) @(posedge hclk);
    else            @(negedge hclk);
    if (use_model) exp_q.push_back(model_f(h));
    #1;
    cur_v = clk_o;
    if (use_model) begin
      e = exp_q.pop_front();
      check_v("clkout_early", cur_v, e);
    end
    #2;
    v2 = clk_o;
    if (use_model) check_v("clkout_late", v2, e);
    for (int i = 0; i < 5; i++) begin
      if (cur_v[i] && !prev_v[i]) begin
        if (rise_ok[i]) begin
          per_h[i] = h - rise_h[i];
          if (per_h[i] * 4 == tbl[i].per_ns)          n_nom[i]++;
          else if (per_h[i] * 4 == tbl[i].per_ns + 8) n_str[i]++;
          else                                        n_oth[i]++;
        end
        rise_h[i]  = h;
        rise_ok[i] = 1'b1;
      end else if (!cur_v[i] && prev_v[i] && rise_ok[i]) begin
        hi_h[i] = h - rise_h[i];
      end
    end
    prev_v = cur_v;
    h++;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 5; i++) begin
      check_i({tag, "_high_ns"}, i, hi_h[i] * 4, tbl[i].hi_ns);
      check_i({tag, "_period_ns"}, i, per_h[i] * 4, tbl[i].per_ns);
    end
  endtask

  initial begin
    tbl[0] = '{2, 8, 16};
    tbl[1] = '{3, 12, 24};
    tbl[2] = '{4, 16, 32};
    tbl[3] = '{5, 20, 40};
    tbl[4] = '{8, 32, 64};
    checks = 0;
    errors = 0;
    h      = 0;
    cur_v  = '0;
    found  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      hi_h[i] = 0; per_h[i] = 0; n_nom[i] = 0; n_str[i] = 0; n_oth[i] = 0;
    end
    clear_edges();

    // Reset state, CALIB tied high through release
    rstn  = 1'b1;
    calib = 1'b1;
    #1 rstn = 1'b0;
    #1 check_v("reset_async", clk_o, 5'b00000);
    repeat (3) begin
      @(posedge hclk); #1 check_v("reset_hold_pos", clk_o, 5'b00000);
      @(negedge hclk); #1 check_v("reset_hold_neg", clk_o, 5'b00000);
    end
    #1 rstn = 1'b1;

    // 100 periods of the divide-by-5 output, all instances against the model
    h = 0;
    repeat (1000) sample_half(1'b1);
    check_table("run1");

    // CALIB held low, then one 2-cycle pulse
    calib = 1'b0;
    repeat (20) sample_half(1'b0);
    for (int i = 0; i < 5; i++) begin
      n_nom[i] = 0; n_str[i] = 0; n_oth[i] = 0;
    end
    calib = 1'b1;
    repeat (4) sample_half(1'b0);
    calib = 1'b0;
    repeat (200) sample_half(1'b0);
    for (int i = 0; i < 5; i++) begin
      check_i("slip_stretched", i, n_str[i], EXP_SLIPS);
      check_i("slip_other", i, n_oth[i], 0);
      check_i("slip_nominal_seen", i, (n_nom[i] > 10) ? 1 : 0, 1);
    end

    // Asynchronous reset in the middle of a divide-by-5 high phase
    for (int k = 0; k < 40 && !found; k++) begin
      sample_half(1'b0);
      if (((h - 1) % 2 == 0) && cur_v[3]) found = 1'b1;
    end
    check_i("find_high_phase", 3, found ? 1 : 0, 1);
    rstn = 1'b0;
    #0.5 check_v("reset_async_mid", clk_o, 5'b00000);
    repeat (3) begin
      @(posedge hclk); #1 check_v("reset_mid_pos", clk_o, 5'b00000);
      @(negedge hclk); #1 check_v("reset_mid_neg", clk_o, 5'b00000);
    end
    #1 rstn = 1'b1;

    // Restart from phase 0 with the same timing as the first run
    h = 0;
    clear_edges();
    repeat (400) sample_half(1'b1);
    check_table("run2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
